// File: rtl/rv32i_pkg.sv
// Shared types for the data-memory arbiter: width defaults, read-owner tag and arbiter FSM states.
package rv32i_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_PIPE,
        OWN_EXT
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIPE,
        ST_EXT,
        ST_EXT_LOCK
    } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: pipeline has priority, the
// external port gets anti-starvation slots and length-limited locked bursts.
module dmem_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int WAIT_W  = $clog2(STARVE_MAX + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    arb_state_e state_q, state_d;
    owner_e     ownerTag_q, ownerTag_d;
    logic [DATA_W-1:0] pRdata_q, eRdata_q;

    logic [WAIT_W-1:0]  waitCnt;
    logic [BURST_W-1:0] burstCnt;
    logic waitFull, burstFull, lockActive, forceRelease;

    assign waitFull   = (waitCnt == WAIT_W'(STARVE_MAX));
    assign burstFull  = (burstCnt == BURST_W'(BURST_MAX));
    assign lockActive = (state_q == ST_EXT_LOCK) && e_req && e_lock;

    always_comb begin
        p_gnt        = 1'b0;
        e_gnt        = 1'b0;
        forceRelease = 1'b0;
        if (rst) begin
            p_gnt = 1'b0;
        end else if (lockActive && burstFull && p_req) begin
            p_gnt        = 1'b1;
            forceRelease = 1'b1;
        end else if (lockActive) begin
            e_gnt = 1'b1;
        end else if (e_req && waitFull) begin
            e_gnt = 1'b1;
        end else if (p_req) begin
            p_gnt = 1'b1;
        end else if (e_req) begin
            e_gnt = 1'b1;
        end
    end

    // The burst stays locked across a forced pipeline slot so it resumes straight after it.
    always_comb begin
        state_d    = ST_IDLE;
        ownerTag_d = OWN_NONE;
        if (forceRelease) begin
            state_d = ST_EXT_LOCK;
        end else if (e_gnt) begin
            state_d = e_lock ? ST_EXT_LOCK : ST_EXT;
        end else if (p_gnt) begin
            state_d = ST_PIPE;
        end
        if (p_gnt && !p_we) begin
            ownerTag_d = OWN_PIPE;
        end else if (e_gnt && !e_we) begin
            ownerTag_d = OWN_EXT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ownerTag_q <= OWN_NONE;
            pRdata_q   <= '0;
            eRdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ownerTag_q <= ownerTag_d;
            pRdata_q   <= p_rdata;
            eRdata_q   <= e_rdata;
        end
    end

    arb_sat_counter #(.MAX(STARVE_MAX), .W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (e_req && !e_gnt),
        .clr_i (!e_req || e_gnt),
        .cnt_o (waitCnt)
    );

    arb_sat_counter #(.MAX(BURST_MAX), .W(BURST_W)) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (e_gnt && e_lock),
        .clr_i (!(e_gnt && e_lock)),
        .cnt_o (burstCnt)
    );

    assign p_stall  = p_req && !p_gnt;
    assign p_rvalid = (ownerTag_q == OWN_PIPE);
    assign e_rvalid = (ownerTag_q == OWN_EXT);
    assign p_rdata  = p_rvalid ? m_rdata : pRdata_q;
    assign e_rdata  = e_rvalid ? m_rdata : eRdata_q;

    always_comb begin
        m_en    = p_gnt || e_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (p_gnt) begin
            m_we    = p_we;
            m_addr  = p_addr;
            m_wdata = p_wdata;
        end else if (e_gnt) begin
            m_we    = e_we;
            m_addr  = e_addr;
            m_wdata = e_wdata;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, data-memory word-address width (1024 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive denied cycles after which the external port wins once.
REQ-004 Parameter BURST_MAX, default 16, maximum consecutive locked external grants.
REQ-005 Port list:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p_req, p_we  in  1 each  pipeline MEM-stage access request, write enable.
- p_addr  in  ADDR_W  pipeline address.
- p_wdata  in  DATA_W  pipeline write data.
- p_gnt  out  1  pipeline granted this cycle.
- p_stall  out  1  pipeline must hold MEM stage.
- p_rvalid  out  1  pipeline read data valid.
- p_rdata  out  DATA_W  pipeline read data.
- e_req, e_we, e_lock  in  1 each  external (loader/debug) request, write enable, burst lock.
- e_addr  in  ADDR_W  external address.
- e_wdata  in  DATA_W  external write data.
- e_gnt  out  1  external port granted this cycle.
- e_rvalid  out  1  external read data valid.
- e_rdata  out  DATA_W  external read data.
- m_en, m_we  out  1 each  memory enable, write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid one cycle after m_en with m_we=0.

Function
REQ-006 At most one of p_gnt/e_gnt SHALL be high per cycle; grants are combinational from requests and registered state.
REQ-007 FSM states: IDLE (no grant last cycle), PIPE (pipeline granted last cycle), EXT (external granted last cycle), EXT_LOCK (external holding a locked burst).
REQ-008 Default priority: pipeline wins when both request.
REQ-009 Counter wait_cnt SHALL increment each cycle e_req is high and e_gnt low, saturate at STARVE_MAX, clear on e_gnt or e_req low.
REQ-010 When wait_cnt == STARVE_MAX and e_req high, external SHALL be granted regardless of p_req.
REQ-011 Granted with e_lock high -> EXT_LOCK; in EXT_LOCK external keeps grant while e_req and e_lock high, up to BURST_MAX grants counted by burst_cnt.
REQ-012 At burst_cnt == BURST_MAX with p_req high, next cycle SHALL grant pipeline (forced release), burst_cnt clears; without p_req, burst continues and burst_cnt holds at BURST_MAX.
REQ-013 e_lock dropping or e_req dropping SHALL exit EXT_LOCK the same cycle (normal arbitration applies).
REQ-014 p_stall = p_req AND NOT p_gnt, combinational.
REQ-015 m_en = p_gnt OR e_gnt; m_we, m_addr, m_wdata muxed from the granted port; all zero when no grant.
REQ-016 Read grant SHALL register owner tag (NONE/PIPE/EXT); next cycle the owner's rvalid is high for exactly one cycle with rdata = m_rdata; the other rvalid stays 0.
REQ-017 Write grants SHALL produce no rvalid; latency read = 1 cycle, write = 0 cycles.
REQ-018 Non-owner rdata SHALL hold its last value; no address wrap handling beyond ADDR_W truncation.
REQ-019 Back-to-back reads from alternating owners SHALL return in grant order, one per cycle, no bubbles.

Reset
REQ-020 rst asserted SHALL immediately force state IDLE, wait_cnt = 0, burst_cnt = 0, owner tag NONE, p_rvalid = e_rvalid = 0, p_rdata = e_rdata = 0.
REQ-021 Reset mid-read SHALL discard the pending return; no rvalid in the first cycle after reset deassertion.
REQ-022 Grant/memory outputs SHALL be 0 while rst is high.

Structure
REQ-023 Shared package rv32i_pkg SHALL hold ADDR_W/DATA_W defaults, owner-tag enum (OWN_NONE, OWN_PIPE, OWN_EXT) and FSM state enum.
REQ-024 One sub-module, arb_sat_counter (saturating counter with clear), SHALL implement both wait_cnt and burst_cnt.

Verification
REQ-025 p_req, e_req both held high, e_lock=0 -> p_gnt 4 cycles, e_gnt on cycle 5 with p_stall=1, then p_gnt resumes.
REQ-026 Pipeline read addr 5 (memory holds 0xDEADBEEF) -> p_rvalid=1 next cycle, p_rdata=0xDEADBEEF, e_rvalid=0.
REQ-027 External locked burst of 20 writes with p_req high throughout -> 16 e_gnt cycles, 1 p_gnt cycle, burst resumes.
REQ-028 Alternating p/e reads addr 1 and 2 -> rvalids alternate each cycle with correct data, no gap.
REQ-029 rst pulsed in the cycle after an external read grant -> e_rvalid never asserts, all outputs 0, state IDLE.
